// File: rtl/chdr_conv_arbiter.sv
// Shares one CHDR sample converter between two input streams: whole packets are granted
// by round-robin or strict priority, and converter output is routed back in grant order.
module chdr_conv_arbiter #(
  parameter logic [7:0] BASE           = 8'd0,
  parameter int         ORDER_DEPTH_L2 = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         set_stb,
  input  logic [7:0]   set_addr,
  input  logic [31:0]  set_data,
  input  logic [127:0] in_tdata,
  input  logic [1:0]   in_tlast,
  input  logic [1:0]   in_tvalid,
  output logic [1:0]   in_tready,
  output logic [63:0]  cv_i_tdata,
  output logic         cv_i_tlast,
  output logic         cv_i_tvalid,
  input  logic         cv_i_tready,
  input  logic [63:0]  cv_o_tdata,
  input  logic         cv_o_tlast,
  input  logic         cv_o_tvalid,
  output logic         cv_o_tready,
  output logic [63:0]  out_tdata,
  output logic         out_tlast,
  output logic [1:0]   out_tvalid,
  input  logic [1:0]   out_tready
);

  // Every stream transfers a beat on a clock edge where tvalid && tready are both high;
  // a source never waits on tready before raising tvalid, and holds its beat until taken.

  typedef enum logic {IDLE, PASS} state_t;

  localparam int DEPTH = 1 << ORDER_DEPTH_L2;

  state_t                    state, state_nx;
  logic [2:0]                ctrl;
  logic                      gnt, rr_last, winner;
  logic [1:0]                elig;
  logic                      push, pop, full, empty, head;
  logic                      order_mem [DEPTH];
  logic [ORDER_DEPTH_L2-1:0] wr_ptr, rd_ptr;
  logic [ORDER_DEPTH_L2:0]   count;
  logic                      unused_set_data;

  assign unused_set_data = ^set_data[31:3];

  always_ff @(posedge clk) begin
    if (!reset_n)
      ctrl <= 3'b011;
    else if (set_stb && set_addr == BASE)
      ctrl <= set_data[2:0];
  end

  assign elig = ctrl[1:0] & in_tvalid;

  // Strict mode favours port0; round-robin prefers the port that did not win last time.
  always_comb begin
    if (ctrl[2])
      winner = !elig[0];
    else if (!rr_last)
      winner = elig[1];
    else
      winner = !elig[0];
  end

  always_comb begin
    state_nx    = state;
    in_tready   = 2'b00;
    cv_i_tvalid = 1'b0;
    cv_i_tdata  = gnt ? in_tdata[127:64] : in_tdata[63:0];
    cv_i_tlast  = in_tlast[gnt];
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (|elig && !full) begin
          push     = 1'b1;
          state_nx = PASS;
        end
      end
      PASS: begin
        cv_i_tvalid    = in_tvalid[gnt];
        in_tready[gnt] = cv_i_tready;
        if (cv_i_tvalid && cv_i_tready && cv_i_tlast)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      state <= state_nx;
      if (push) begin
        gnt     <= winner;
        rr_last <= winner;
      end
    end
  end

  // Grant-order FIFO: one entry per packet handed to the converter but not yet returned.
  always_ff @(posedge clk) begin
    if (push)
      order_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = count[ORDER_DEPTH_L2];
  assign head  = order_mem[rd_ptr];

  always_comb begin
    out_tvalid = 2'b00;
    if (!empty)
      out_tvalid[head] = cv_o_tvalid;
  end

  assign cv_o_tready = !empty && out_tready[head];
  assign pop         = cv_o_tvalid && cv_o_tready && cv_o_tlast;
  assign out_tdata   = cv_o_tdata;
  assign out_tlast   = cv_o_tlast;

endmodule

// File: tb/tb_chdr_conv_arbiter.sv
// Directed bench for chdr_conv_arbiter: packet-level arbitration model, bench-side
// converter (passthrough or 2:1 packing) and per-port output scoreboards.
module tb_chdr_conv_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         set_stb;
  logic [7:0]   set_addr;
  logic [31:0]  set_data;
  logic [127:0] in_tdata;
  logic [1:0]   in_tlast, in_tvalid, in_tready;
  logic [63:0]  cv_i_tdata;
  logic         cv_i_tlast, cv_i_tvalid, cv_i_tready;
  logic [63:0]  cv_o_tdata;
  logic         cv_o_tlast, cv_o_tvalid, cv_o_tready;
  logic [63:0]  out_tdata;
  logic         out_tlast;
  logic [1:0]   out_tvalid, out_tready;

  chdr_conv_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .cv_i_tdata(cv_i_tdata), .cv_i_tlast(cv_i_tlast), .cv_i_tvalid(cv_i_tvalid), .cv_i_tready(cv_i_tready),
    .cv_o_tdata(cv_o_tdata), .cv_o_tlast(cv_o_tlast), .cv_o_tvalid(cv_o_tvalid), .cv_o_tready(cv_o_tready),
    .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // ---------------- bench state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [64:0] src0_q[$], src1_q[$], cvo_q[$];
  logic [64:0] exp_q[$], exp_o0_q[$], exp_o1_q[$];
  int load_k[2], exp_k[2];
  int plen[2][32];
  bit pack_mode, cv_hold, rand_out, rand_cvi, check_bubble;
  bit have_half;
  logic [31:0] half;
  int cvi_pkts, cvi_beats;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic extra_beat(input string name, input logic [64:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: unexpected beat %h, expected none", name, act);
  endtask

  function automatic logic [63:0] beat_data(input int p, input int k, input int b);
    logic [7:0]  pb, kb;
    logic [15:0] bb;
    logic [31:0] lo;
    pb = 8'hC0 | 8'(p);
    kb = 8'(k);
    bb = 16'(b);
    lo = 32'h1357_0000 + 32'(p * 4099 + k * 257 + b * 17);
    return {pb, kb, bb, lo};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load(input int p, input int n, input int len);
    for (int i = 0; i < n; i++) begin
      int k;
      k = load_k[p];
      load_k[p]++;
      plen[p][k] = len;
      for (int b = 0; b < len; b++) begin
        logic [64:0] v;
        v = {(b == len - 1), beat_data(p, k, b)};
        if (p == 0) src0_q.push_back(v);
        else        src1_q.push_back(v);
      end
    end
  endtask

  task automatic wr_ctrl(input logic [7:0] addr, input logic [2:0] val);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = {29'h0, val};
    cyc();
    set_stb  = 1'b0;
    set_data = 32'h0;
  endtask

  task automatic flush();
    src0_q.delete(); src1_q.delete(); cvo_q.delete();
    exp_q.delete(); exp_o0_q.delete(); exp_o1_q.delete();
    have_half = 1'b0;
    exp_k = load_k;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush();
    pack_mode = 0; cv_hold = 0; rand_out = 0; rand_cvi = 0; check_bubble = 0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  // ---------------- behavioural model ----------------
  task automatic expect_pkt(input int p);
    int k, len;
    logic [63:0] d0, d1;
    logic [64:0] v;
    k = exp_k[p];
    exp_k[p]++;
    len = plen[p][k];
    for (int b = 0; b < len; b++) begin
      v = {(b == len - 1), beat_data(p, k, b)};
      exp_q.push_back(v);
      if (!pack_mode) begin
        if (p == 0) exp_o0_q.push_back(v);
        else        exp_o1_q.push_back(v);
      end
    end
    if (pack_mode) begin
      for (int b = 0; b < len; b += 2) begin
        d0 = beat_data(p, k, b);
        if (b + 1 < len) begin
          d1 = beat_data(p, k, b + 1);
          v = {(b + 1 == len - 1), d1[31:0], d0[31:0]};
        end else begin
          v = {1'b1, 32'h0, d0[31:0]};
        end
        if (p == 0) exp_o0_q.push_back(v);
        else        exp_o1_q.push_back(v);
      end
    end
  endtask

  // Packet-level arbitration: every port with packets left is eligible at each decision.
  // Enables are ca for the first sw grants, cb afterwards. ord bit i = port of grant i.
  task automatic build_expect(input int n0, input int n1, input logic [2:0] ca, input int sw,
                              input logic [2:0] cb, output logic [7:0] ord);
    int cnt[2];
    int last, w;
    logic [2:0] en;
    bit e0, e1;
    cnt[0] = n0; cnt[1] = n1;
    last = 1;
    ord = 8'h0;
    for (int i = 0; i < 8; i++) begin
      en = (i >= sw) ? cb : ca;
      e0 = en[0] && cnt[0] > 0;
      e1 = en[1] && cnt[1] > 0;
      if (!e0 && !e1) break;
      if (en[2])          w = e0 ? 0 : 1;
      else if (last == 0) w = e1 ? 1 : 0;
      else                w = e0 ? 0 : 1;
      ord[i] = (w == 1);
      expect_pkt(w);
      cnt[w]--;
      last = w;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int t;
    t = 0;
    while ((exp_q.size() + exp_o0_q.size() + exp_o1_q.size()) != 0 && t < budget) begin
      cyc();
      t++;
    end
    check(name, 65'(exp_q.size() + exp_o0_q.size() + exp_o1_q.size()), 65'd0);
  endtask

  // ---------------- source / converter / sink model ----------------
  initial begin
    bit act, cvi_hs, cvo_hs;
    logic [1:0] in_hs;
    logic [64:0] cvi_beat;
    in_tdata = '0; in_tlast = '0; in_tvalid = '0;
    cv_i_tready = 1'b1; cv_o_tdata = '0; cv_o_tlast = 1'b0; cv_o_tvalid = 1'b0;
    out_tready = 2'b11;
    forever begin
      @(negedge clk);
      act      = reset_n;
      in_hs    = in_tvalid & in_tready;
      cvi_hs   = cv_i_tvalid && cv_i_tready;
      cvi_beat = {cv_i_tlast, cv_i_tdata};
      cvo_hs   = cv_o_tvalid && cv_o_tready;
      @(posedge clk);
      #1;
      if (act) begin
        if (in_hs[0]) void'(src0_q.pop_front());
        if (in_hs[1]) void'(src1_q.pop_front());
        if (cvo_hs)   void'(cvo_q.pop_front());
        if (cvi_hs) begin
          if (!pack_mode) begin
            cvo_q.push_back(cvi_beat);
          end else if (!have_half) begin
            if (cvi_beat[64]) cvo_q.push_back({1'b1, 32'h0, cvi_beat[31:0]});
            else begin half = cvi_beat[31:0]; have_half = 1'b1; end
          end else begin
            cvo_q.push_back({cvi_beat[64], cvi_beat[31:0], half});
            have_half = 1'b0;
          end
        end
      end
      if (src0_q.size() > 0) begin
        in_tvalid[0] = 1'b1; {in_tlast[0], in_tdata[63:0]} = src0_q[0];
      end else begin
        in_tvalid[0] = 1'b0; in_tlast[0] = 1'b0; in_tdata[63:0] = '0;
      end
      if (src1_q.size() > 0) begin
        in_tvalid[1] = 1'b1; {in_tlast[1], in_tdata[127:64]} = src1_q[0];
      end else begin
        in_tvalid[1] = 1'b0; in_tlast[1] = 1'b0; in_tdata[127:64] = '0;
      end
      if (cvo_q.size() > 0) {cv_o_tlast, cv_o_tdata} = cvo_q[0];
      else                  {cv_o_tlast, cv_o_tdata} = '0;
      cv_o_tvalid = !cv_hold && cvo_q.size() > 0;
      cv_i_tready = rand_cvi ? 1'($urandom_range(0, 1)) : 1'b1;
      out_tready  = rand_out ? 2'($urandom_range(0, 3)) : 2'b11;
    end
  end

  // ---------------- scoreboard / compare process ----------------
  bit gap_arm = 0;
  int gap = 0;
  always @(negedge clk) begin
    logic [64:0] b;
    if (!check_bubble) gap_arm = 0;
    if (reset_n) begin
      check("in_tready_onehot", 65'($countones(in_tready) <= 1), 65'd1);
      check("out_tvalid_onehot", 65'($countones(out_tvalid) <= 1), 65'd1);
      if (check_bubble && gap_arm) begin
        if (cv_i_tvalid) begin
          check("idle_bubble", 65'(gap), 65'd1);
          gap_arm = 0;
        end else begin
          gap++;
        end
      end
      if (cv_i_tvalid && cv_i_tready) begin
        b = {cv_i_tlast, cv_i_tdata};
        cvi_beats++;
        if (cv_i_tlast) begin
          cvi_pkts++;
          gap_arm = check_bubble;
          gap = 0;
        end
        if (exp_q.size() == 0) extra_beat("cv_i_extra", b);
        else                   check("cv_i_beat", b, exp_q.pop_front());
      end
      b = {out_tlast, out_tdata};
      if (out_tvalid[0] && out_tready[0]) begin
        if (exp_o0_q.size() == 0) extra_beat("out0_extra", b);
        else                      check("out0_beat", b, exp_o0_q.pop_front());
      end
      if (out_tvalid[1] && out_tready[1]) begin
        if (exp_o1_q.size() == 0) extra_beat("out1_extra", b);
        else                      check("out1_beat", b, exp_o1_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed phases ----------------
  initial begin
    logic [7:0] ord;
    int t;
    reset_n = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    pack_mode = 0; cv_hold = 0; rand_out = 0; rand_cvi = 0; check_bubble = 0;
    load_k[0] = 0; load_k[1] = 0; exp_k[0] = 0; exp_k[1] = 0;
    cvi_pkts = 0; cvi_beats = 0;
    repeat (3) cyc();
    check("reset_in_tready", 65'(in_tready), 65'd0);
    check("reset_cv_i_tvalid", 65'(cv_i_tvalid), 65'd0);
    check("reset_out_tvalid", 65'(out_tvalid), 65'd0);
    check("reset_cv_o_tready", 65'(cv_o_tready), 65'd0);
    reset_n = 1'b1;
    cyc();

    // Round-robin, passthrough; a write to a foreign address must not touch ctrl.
    wr_ctrl(8'h01, 3'b000);
    exp_k = load_k;
    load(0, 2, 3); load(1, 2, 3);
    build_expect(2, 2, 3'b011, 99, 3'b011, ord);
    check("model_rr_order", 65'(ord), 65'h0A);
    check_bubble = 1;
    drain("rr_drain", 400);
    check_bubble = 0;

    // Strict priority: port1 waits until port0 runs dry.
    do_reset();
    wr_ctrl(8'h00, 3'b111);
    load(0, 3, 3); load(1, 2, 3);
    build_expect(3, 2, 3'b111, 99, 3'b111, ord);
    check("model_strict_order", 65'(ord), 65'h18);
    drain("strict_drain", 400);

    // Converter output stalled: four grants fill the order FIFO, the fifth waits.
    do_reset();
    cv_hold = 1;
    load(0, 3, 2); load(1, 2, 2);
    build_expect(3, 2, 3'b011, 99, 3'b011, ord);
    check("model_full_order", 65'(ord), 65'h0A);
    cvi_pkts = 0;
    repeat (40) cyc();
    check("full_grants_held", 65'(cvi_pkts), 65'd4);
    check("full_in_tready", 65'(in_tready), 65'd0);
    check("full_cv_i_tvalid", 65'(cv_i_tvalid), 65'd0);
    check("full_out_tvalid", 65'(out_tvalid), 65'd0);
    cv_hold = 0;
    drain("full_drain", 400);
    check("full_all_granted", 65'(cvi_pkts), 65'd5);

    // Disable port0 while its packet is in flight.
    do_reset();
    load(0, 2, 6); load(1, 2, 2);
    build_expect(2, 2, 3'b011, 1, 3'b010, ord);
    check("model_disable_order", 65'(ord), 65'h06);
    t = 0;
    while (!in_tready[0] && t < 20) begin cyc(); t++; end
    check("disable_p0_in_pass", 65'(in_tready[0]), 65'd1);
    wr_ctrl(8'h00, 3'b010);
    drain("disable_drain", 400);
    repeat (20) cyc();

    // Reset in the middle of a packet.
    do_reset();
    load(0, 1, 6); load(1, 1, 6);
    build_expect(1, 1, 3'b011, 99, 3'b011, ord);
    cvi_beats = 0;
    t = 0;
    while (cvi_beats < 2 && t < 20) begin cyc(); t++; end
    check("midpkt_reached", 65'(cvi_beats >= 2), 65'd1);
    reset_n = 1'b0;
    flush();
    cvo_q.push_back({1'b1, 64'hDEAD_BEEF_0000_0001});
    load(0, 1, 2); load(1, 1, 2);
    build_expect(1, 1, 3'b011, 99, 3'b011, ord);
    check("model_post_reset_order", 65'(ord), 65'h02);
    cyc();
    check("midrst_in_tready", 65'(in_tready), 65'd0);
    check("midrst_cv_i_tvalid", 65'(cv_i_tvalid), 65'd0);
    check("midrst_out_tvalid", 65'(out_tvalid), 65'd0);
    check("midrst_cv_o_tready", 65'(cv_o_tready), 65'd0);
    cvo_q.delete();
    cyc();
    reset_n = 1'b1;
    drain("post_reset_drain", 400);

    // 2:1 packing converter with random backpressure on both sides.
    do_reset();
    pack_mode = 1; rand_out = 1; rand_cvi = 1;
    load(0, 3, 5); load(1, 3, 5);
    build_expect(3, 3, 3'b011, 99, 3'b011, ord);
    check("model_pack_order", 65'(ord), 65'h2A);
    check("model_pack_beats", 65'(exp_o0_q.size() + exp_o1_q.size()), 65'd18);
    drain("pack_drain", 3000);
    rand_out = 0; rand_cvi = 0;
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
